// File: rtl/wiphase_ram_pkg.sv
// Shared types, defaults and helpers for the wiphase RAM family
// (lookahead RAM, test-pattern generator tables).
package wiphase_ram_pkg;

  localparam int unsigned WIPHASE_RAM_DATA_WIDTH = 16;
  localparam int unsigned WIPHASE_RAM_DEPTH      = 8;
  localparam int unsigned WIPHASE_RAM_NUM_RD     = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/wiphase_lookahead_ram_rdport.sv
// One read port of the lookahead RAM: registers the array word, the bypass
// decision and the concurrent write, then merges them one cycle later.
module wiphase_lookahead_ram_rdport #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_en,
  input  logic                  bypass,
  input  logic [DATA_WIDTH-1:0] arr_word,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic [DATA_WIDTH-1:0] rd_readdata,
  output logic                  rd_readdatavalid
);

  logic [DATA_WIDTH-1:0] arr_q, arr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic                  byp_q, byp_d;
  logic                  valid_q, valid_d;

  // Registers only move on an accepted read, so the merged output holds
  // its last value whenever valid is low.
  always_comb begin
    arr_d   = arr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    byp_d   = byp_q;
    valid_d = rd_en;
    if (rd_en) begin
      arr_d   = arr_word;
      wdata_d = wr_data;
      mask_d  = wr_mask;
      byp_d   = bypass;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arr_q   <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      byp_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      arr_q   <= arr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      byp_q   <= byp_d;
      valid_q <= valid_d;
    end
  end

  assign rd_readdata      = byp_q ? ((wdata_q & mask_q) | (arr_q & ~mask_q)) : arr_q;
  assign rd_readdatavalid = valid_q;

endmodule

// File: rtl/wiphase_lookahead_ram.sv
// Multi-read-port RAM with write-to-read lookahead and hardware clear FSM.
// Optional byte enables: define WIPHASE_LOOKAHEAD_RAM_BYTEEN_EN.
module wiphase_lookahead_ram
  import wiphase_ram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = WIPHASE_RAM_DATA_WIDTH,
  parameter int unsigned           DEPTH          = WIPHASE_RAM_DEPTH,
  parameter int unsigned           ADDR_WIDTH     = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1,
  parameter int unsigned           NUM_RD         = WIPHASE_RAM_NUM_RD,
  parameter int unsigned           CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ADDR_WIDTH-1:0]        wr_address,
  input  logic [DATA_WIDTH-1:0]        wr_writedata,
  input  logic                         wr_write,
`ifdef WIPHASE_LOOKAHEAD_RAM_BYTEEN_EN
  input  logic [DATA_WIDTH/8-1:0]      wr_byteenable,
`endif
  output logic                         wr_waitrequest,
  input  logic                         clear_req,
  input  logic [NUM_RD-1:0]            rd_read,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_address,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_readdata,
  output logic [NUM_RD-1:0]            rd_readdatavalid
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
  localparam ram_state_e            RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  wait_q, wait_d;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  wr_accept;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_wmask;

`ifdef WIPHASE_LOOKAHEAD_RAM_BYTEEN_EN
  if (DATA_WIDTH % 8 != 0) begin : g_be_width_check
    $error("wiphase_lookahead_ram: DATA_WIDTH must be a multiple of 8 with byte enables");
  end

  always_comb begin
    wr_mask = '0;
    for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
      wr_mask[b*8 +: 8] = {8{wr_byteenable[b]}};
    end
  end
`else
  assign wr_mask = '1;
`endif

  assign wr_accept      = wr_write && !wait_q && (32'(wr_address) < DEPTH);
  assign wr_waitrequest = wait_q;

  // The clear owns the array write port; user writes only land in READY.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wait_d    = wait_q;
    mem_we    = 1'b0;
    mem_waddr = wr_address;
    mem_wdata = wr_writedata;
    mem_wmask = wr_mask;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = count_q;
        mem_wdata = CLEAR_VALUE;
        mem_wmask = '1;
        if (count_q == '0) begin
          state_d = ST_READY;
          wait_d  = 1'b0;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      ST_READY: begin
        wait_d = 1'b0;
        mem_we = wr_accept;
        if (clear_req) begin
          state_d = ST_CLEAR;
          count_d = LAST_ADDR;
          wait_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_STATE;
      count_q <= LAST_ADDR;
      wait_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= (mem_q[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] arr_word;

    assign addr     = rd_address[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign in_range = 32'(addr) < DEPTH;
    assign arr_word = in_range ? mem_q[addr] : CLEAR_VALUE;

    // A hit implies an in-range address since wr_accept already checks it.
    wiphase_lookahead_ram_rdport #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_rdport (
      .clk             (clk),
      .reset_n         (reset_n),
      .rd_en           (rd_read[g] && (state_q == ST_READY)),
      .bypass          (wr_accept && (addr == wr_address)),
      .arr_word        (arr_word),
      .wr_data         (wr_writedata),
      .wr_mask         (wr_mask),
      .rd_readdata     (rd_readdata[g*DATA_WIDTH +: DATA_WIDTH]),
      .rd_readdatavalid(rd_readdatavalid[g])
    );
  end

endmodule

// File: tb/tb_wiphase_lookahead_ram.sv
// Self-checking bench for wiphase_lookahead_ram: directed scenarios plus a
// random soak against a post-write array model.
module tb_wiphase_lookahead_ram;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int NRD   = 2;

  logic              clk;
  logic              reset_n;
  logic [AW-1:0]     wr_address;
  logic [DW-1:0]     wr_writedata;
  logic              wr_write;
  logic              wr_waitrequest;
  logic              clear_req;
  logic [NRD-1:0]    rd_read;
  logic [NRD*AW-1:0] rd_address;
  logic [NRD*DW-1:0] rd_readdata;
  logic [NRD-1:0]    rd_readdatavalid;
`ifdef WIPHASE_LOOKAHEAD_RAM_BYTEEN_EN
  logic [DW/8-1:0]   wr_byteenable;
  logic [DW/8-1:0]   w6_be;
`endif

  logic [2:0]  w6_address;
  logic [15:0] w6_data;
  logic        w6_write;
  logic        w6_wait;
  logic        w6_clear;
  logic [0:0]  w6_read;
  logic [2:0]  w6_raddr;
  logic [15:0] w6_rdata;
  logic [0:0]  w6_valid;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0]  model_mem [DEPTH];
  logic [DW-1:0]  exp_data  [NRD];
  logic [NRD-1:0] exp_valid;
  int             clear_left;

  wiphase_lookahead_ram dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .wr_address      (wr_address),
    .wr_writedata    (wr_writedata),
    .wr_write        (wr_write),
`ifdef WIPHASE_LOOKAHEAD_RAM_BYTEEN_EN
    .wr_byteenable   (wr_byteenable),
`endif
    .wr_waitrequest  (wr_waitrequest),
    .clear_req       (clear_req),
    .rd_read         (rd_read),
    .rd_address      (rd_address),
    .rd_readdata     (rd_readdata),
    .rd_readdatavalid(rd_readdatavalid)
  );

  wiphase_lookahead_ram #(
    .DATA_WIDTH (16),
    .DEPTH      (6),
    .NUM_RD     (1),
    .CLEAR_VALUE(16'h5A5A)
  ) dut6 (
    .clk             (clk),
    .reset_n         (reset_n),
    .wr_address      (w6_address),
    .wr_writedata    (w6_data),
    .wr_write        (w6_write),
`ifdef WIPHASE_LOOKAHEAD_RAM_BYTEEN_EN
    .wr_byteenable   (w6_be),
`endif
    .wr_waitrequest  (w6_wait),
    .clear_req       (w6_clear),
    .rd_read         (w6_read),
    .rd_address      (w6_raddr),
    .rd_readdata     (w6_rdata),
    .rd_readdatavalid(w6_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    wr_address = '0; wr_writedata = '0; wr_write = 1'b0; clear_req = 1'b0;
    rd_read = '0; rd_address = '0;
    w6_address = '0; w6_data = '0; w6_write = 1'b0; w6_clear = 1'b0;
    w6_read = '0; w6_raddr = '0;
`ifdef WIPHASE_LOOKAHEAD_RAM_BYTEEN_EN
    wr_byteenable = '1; w6_be = '1;
`endif
  endtask

  task automatic model_reset();
    clear_left = DEPTH;
    exp_valid  = '0;
    for (int i = 0; i < NRD; i++) exp_data[i] = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  // Reads return the array as it stands after this edge's write; a clear
  // wipes the whole array before anything can observe it again.
  task automatic tick();
    int unsigned   wa;
    int unsigned   ra;
    logic [DW-1:0] m;
    wa = 32'(wr_address);
    m  = '1;
`ifdef WIPHASE_LOOKAHEAD_RAM_BYTEEN_EN
    m = {{8{wr_byteenable[1]}}, {8{wr_byteenable[0]}}};
`endif
    if (wr_write && clear_left == 0 && wa < DEPTH)
      model_mem[wa] = (model_mem[wa] & ~m) | (wr_writedata & m);
    for (int p = 0; p < NRD; p++) begin
      ra = 32'(rd_address[p*AW +: AW]);
      exp_valid[p] = rd_read[p] && clear_left == 0;
      if (exp_valid[p]) exp_data[p] = model_mem[ra];
    end
    if (clear_left > 0) clear_left--;
    else if (clear_req) begin
      clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_waitrequest !== 1'b1 || rd_readdatavalid !== 2'b00 || rd_readdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got wait=%b valid=%b data=%h, expected wait=1 valid=00 data=00000000",
               wr_waitrequest, rd_readdatavalid, rd_readdata);
    end
    model_reset();
    reset_n = 1'b1;
    for (int e = 1; e <= DEPTH; e++) begin
      tick();
      checks++;
      if (wr_waitrequest !== (e < DEPTH)) begin
        failures++;
        $display("FAIL reset_clear_wait edge %0d: got %b, expected %b", e, wr_waitrequest, e < DEPTH);
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_read    = 2'b11;
      rd_address = {3'(DEPTH - 1 - a), 3'(a)};
      tick();
      checks++;
      if (rd_readdatavalid !== 2'b11 || rd_readdata !== 32'h0) begin
        failures++;
        $display("FAIL reset_cleared_read addr %0d: got valid=%b data=%h, expected valid=11 data=00000000",
                 a, rd_readdatavalid, rd_readdata);
      end
    end
    idle();
    tick();
    checks++;
    if (rd_readdatavalid !== 2'b00) begin
      failures++;
      $display("FAIL valid_single_cycle: got %b, expected 00", rd_readdatavalid);
    end
  endtask

  task automatic test_lookahead();
    idle();
    wr_write = 1'b1; wr_address = 3'd3; wr_writedata = 16'hBEEF;
    rd_read = 2'b01; rd_address = {3'd0, 3'd3};
    tick();
    checks++;
    if (rd_readdatavalid !== 2'b01 || rd_readdata[15:0] !== 16'hBEEF) begin
      failures++;
      $display("FAIL lookahead_p0: got valid=%b data=%h, expected valid=01 data=beef",
               rd_readdatavalid, rd_readdata[15:0]);
    end
    idle();
    rd_read = 2'b10; rd_address = {3'd3, 3'd0};
    tick();
    checks++;
    if (rd_readdatavalid !== 2'b10 || rd_readdata !== 32'hBEEF_BEEF) begin
      failures++;
      $display("FAIL lookahead_p1_followup: got valid=%b data=%h, expected valid=10 data=beefbeef",
               rd_readdatavalid, rd_readdata);
    end
    idle();
    wr_write = 1'b1; wr_address = 3'd6; wr_writedata = 16'h5678;
    rd_read = 2'b11; rd_address = {3'd6, 3'd6};
    tick();
    checks++;
    if (rd_readdatavalid !== 2'b11 || rd_readdata !== 32'h5678_5678) begin
      failures++;
      $display("FAIL lookahead_both_ports: got valid=%b data=%h, expected valid=11 data=56785678",
               rd_readdatavalid, rd_readdata);
    end
  endtask

  task automatic test_runtime_clear();
    for (int a = 0; a < DEPTH; a++) begin
      idle();
      wr_write = 1'b1; wr_address = 3'(a); wr_writedata = 16'h1111;
      tick();
    end
    idle();
    rd_read = 2'b11; rd_address = {3'd7, 3'd4};
    tick();
    checks++;
    if (rd_readdatavalid !== 2'b11 || rd_readdata !== 32'h1111_1111) begin
      failures++;
      $display("FAIL fill_readback: got valid=%b data=%h, expected valid=11 data=11111111",
               rd_readdatavalid, rd_readdata);
    end
    idle();
    wr_write = 1'b1; wr_address = 3'd5; wr_writedata = 16'h2222; clear_req = 1'b1;
    rd_read = 2'b01; rd_address = {3'd0, 3'd5};
    tick();
    checks++;
    if (wr_waitrequest !== 1'b1 || rd_readdatavalid !== 2'b01 || rd_readdata[15:0] !== 16'h2222) begin
      failures++;
      $display("FAIL clear_req_edge: got wait=%b valid=%b data=%h, expected wait=1 valid=01 data=2222",
               wr_waitrequest, rd_readdatavalid, rd_readdata[15:0]);
    end
    for (int e = 1; e <= DEPTH; e++) begin
      idle();
      rd_read = 2'b11; rd_address = {3'd5, 3'(e - 1)};
      if (e == 3) begin
        wr_write = 1'b1; wr_address = 3'd2; wr_writedata = 16'hAAAA;
      end
      if (e == 4) clear_req = 1'b1;
      tick();
      checks++;
      if (rd_readdatavalid !== 2'b00 || wr_waitrequest !== (e < DEPTH) || rd_readdata !== 32'h1111_2222) begin
        failures++;
        $display("FAIL during_clear edge %0d: got valid=%b wait=%b data=%h, expected valid=00 wait=%b data=11112222",
                 e, rd_readdatavalid, wr_waitrequest, rd_readdata, e < DEPTH);
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      idle();
      rd_read = 2'b11; rd_address = {3'(a), 3'(a)};
      tick();
      checks++;
      if (rd_readdatavalid !== 2'b11 || rd_readdata !== 32'h0) begin
        failures++;
        $display("FAIL after_clear addr %0d: got valid=%b data=%h, expected valid=11 data=00000000",
                 a, rd_readdatavalid, rd_readdata);
      end
    end
  endtask

  task automatic test_out_of_range();
    idle();
    w6_write = 1'b1; w6_address = 3'd6; w6_data = 16'h1234; w6_read = 1'b1; w6_raddr = 3'd6;
    tick();
    checks++;
    if (w6_valid !== 1'b1 || w6_rdata !== 16'h5A5A) begin
      failures++;
      $display("FAIL oor_no_bypass: got valid=%b data=%h, expected valid=1 data=5a5a", w6_valid, w6_rdata);
    end
    idle();
    w6_write = 1'b1; w6_address = 3'd5; w6_data = 16'h7777; w6_read = 1'b1; w6_raddr = 3'd5;
    tick();
    checks++;
    if (w6_valid !== 1'b1 || w6_rdata !== 16'h7777) begin
      failures++;
      $display("FAIL depth6_last_bypass: got valid=%b data=%h, expected valid=1 data=7777", w6_valid, w6_rdata);
    end
    idle();
    w6_read = 1'b1; w6_raddr = 3'd7;
    tick();
    checks++;
    if (w6_valid !== 1'b1 || w6_rdata !== 16'h5A5A) begin
      failures++;
      $display("FAIL oor_read7: got valid=%b data=%h, expected valid=1 data=5a5a", w6_valid, w6_rdata);
    end
    idle();
    w6_read = 1'b1; w6_raddr = 3'd5;
    tick();
    checks++;
    if (w6_valid !== 1'b1 || w6_rdata !== 16'h7777) begin
      failures++;
      $display("FAIL depth6_stored: got valid=%b data=%h, expected valid=1 data=7777", w6_valid, w6_rdata);
    end
    idle();
    w6_read = 1'b1; w6_raddr = 3'd0;
    tick();
    checks++;
    if (w6_valid !== 1'b1 || w6_rdata !== 16'h5A5A) begin
      failures++;
      $display("FAIL depth6_clear_value: got valid=%b data=%h, expected valid=1 data=5a5a", w6_valid, w6_rdata);
    end
  endtask

`ifdef WIPHASE_LOOKAHEAD_RAM_BYTEEN_EN
  task automatic test_byteenable();
    idle();
    wr_write = 1'b1; wr_address = 3'd1; wr_writedata = 16'h1234; wr_byteenable = 2'b11;
    tick();
    idle();
    wr_write = 1'b1; wr_address = 3'd1; wr_writedata = 16'hAB00; wr_byteenable = 2'b10;
    rd_read = 2'b01; rd_address = {3'd0, 3'd1};
    tick();
    checks++;
    if (rd_readdatavalid !== 2'b01 || rd_readdata[15:0] !== 16'hAB34) begin
      failures++;
      $display("FAIL byteen_bypass: got valid=%b data=%h, expected valid=01 data=ab34",
               rd_readdatavalid, rd_readdata[15:0]);
    end
    idle();
    rd_read = 2'b10; rd_address = {3'd1, 3'd0};
    tick();
    checks++;
    if (rd_readdata[31:16] !== 16'hAB34) begin
      failures++;
      $display("FAIL byteen_stored: got %h, expected ab34", rd_readdata[31:16]);
    end
  endtask
`endif

  task automatic test_async_reset();
    idle();
    wr_write = 1'b1; wr_address = 3'd1; wr_writedata = 16'h3C3C;
    rd_read = 2'b01; rd_address = {3'd0, 3'd1};
    tick();
    checks++;
    if (rd_readdatavalid !== 2'b01 || rd_readdata[15:0] !== 16'h3C3C) begin
      failures++;
      $display("FAIL pre_reset_read: got valid=%b data=%h, expected valid=01 data=3c3c",
               rd_readdatavalid, rd_readdata[15:0]);
    end
    idle();
    rd_read = 2'b11;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (wr_waitrequest !== 1'b1 || rd_readdatavalid !== 2'b00 || rd_readdata !== 32'h0) begin
      failures++;
      $display("FAIL async_reset_outputs: got wait=%b valid=%b data=%h, expected wait=1 valid=00 data=00000000",
               wr_waitrequest, rd_readdatavalid, rd_readdata);
    end
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
    for (int e = 1; e <= DEPTH; e++) begin
      tick();
      checks++;
      if (wr_waitrequest !== (e < DEPTH)) begin
        failures++;
        $display("FAIL async_restart_wait edge %0d: got %b, expected %b", e, wr_waitrequest, e < DEPTH);
      end
    end
    rd_read = 2'b01; rd_address = {3'd0, 3'd1};
    tick();
    checks++;
    if (rd_readdatavalid !== 2'b01 || rd_readdata[15:0] !== 16'h0000) begin
      failures++;
      $display("FAIL async_restart_cleared: got valid=%b data=%h, expected valid=01 data=0000",
               rd_readdatavalid, rd_readdata[15:0]);
    end
  endtask

  task automatic test_soak();
    for (int c = 0; c < 2000; c++) begin
      idle();
      wr_write     = 1'($urandom_range(0, 1));
      wr_address   = 3'($urandom_range(0, DEPTH - 1));
      wr_writedata = 16'($urandom);
      clear_req    = ($urandom_range(0, 99) == 0);
      rd_read      = 2'($urandom);
      rd_address   = 6'($urandom);
      if ($urandom_range(0, 3) == 0) rd_address[2:0] = wr_address;
      if ($urandom_range(0, 3) == 0) rd_address[5:3] = wr_address;
`ifdef WIPHASE_LOOKAHEAD_RAM_BYTEEN_EN
      wr_byteenable = 2'($urandom);
`endif
      tick();
      checks++;
      if (wr_waitrequest !== (clear_left > 0)) begin
        failures++;
        $display("FAIL soak_wait cycle %0d: got %b, expected %b", c, wr_waitrequest, clear_left > 0);
      end
      checks++;
      if (rd_readdatavalid !== exp_valid) begin
        failures++;
        $display("FAIL soak_valid cycle %0d: got %b, expected %b", c, rd_readdatavalid, exp_valid);
      end
      for (int p = 0; p < NRD; p++) begin
        checks++;
        if (rd_readdata[p*DW +: DW] !== exp_data[p]) begin
          failures++;
          $display("FAIL soak_data cycle %0d port %0d: got %h, expected %h",
                   c, p, rd_readdata[p*DW +: DW], exp_data[p]);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    test_reset();
    test_lookahead();
    test_runtime_clear();
    test_out_of_range();
`ifdef WIPHASE_LOOKAHEAD_RAM_BYTEEN_EN
    test_byteenable();
`endif
    test_async_reset();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
